pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 8, data path width in bits.
REQ-002 Parameter RESET_VAL, default 0, value loaded into both data registers on reset.
REQ-003 clkrst_core_clk  input  1  single core clock; all state changes on its rising edge.
REQ-004 clkrst_core_rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  WIDTH  upstream data word.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_data  output  WIDTH  downstream data word, taken directly from the main register.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 flush  input  1  discard all held words.
REQ-012 occupancy  output  2  number of words held (0..2).

Function
REQ-013 The block SHALL be a 2-entry valid/ready pipeline register with a main register and a skid register, and states EMPTY (0 words), BUSY (main full), FULL (main and skid full).
REQ-014 Accept SHALL mean in_valid && in_ready; pop SHALL mean out_valid && out_ready.
REQ-015 in_ready SHALL be 1 in EMPTY and BUSY and 0 in FULL, decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-016 out_valid SHALL be 1 in BUSY and FULL and 0 in EMPTY; occupancy SHALL be 0/1/2 for EMPTY/BUSY/FULL.
REQ-017 EMPTY: accept -> BUSY, main <= in_data; no accept -> stay EMPTY.
REQ-018 BUSY: accept && !pop -> FULL, skid <= in_data; pop && !accept -> EMPTY; accept && pop -> stay BUSY, main <= in_data; neither -> stay BUSY.
REQ-019 FULL: pop -> BUSY, main <= skid; no pop -> stay FULL, both registers hold.
REQ-020 Latency from accept to out_valid SHALL be exactly 1 cycle when the block is EMPTY.
REQ-021 Words SHALL leave in strict acceptance order; no word SHALL be dropped or duplicated except by flush or reset.
REQ-022 While out_valid && !out_ready, out_data SHALL remain unchanged.
REQ-023 flush SHALL force the next state to EMPTY with priority over accept and pop; a word presented in the flush cycle SHALL be discarded; data registers hold their contents.
REQ-024 Data registers SHALL load only on the transitions listed in REQ-017 to REQ-019; no other cycle SHALL change them.
REQ-025 Sustained in_valid=1 and out_ready=1 SHALL give one word per cycle throughput with state remaining BUSY.

Reset
REQ-026 When clkrst_core_rst=1 at a rising edge, next state SHALL be EMPTY and main and skid SHALL be RESET_VAL, giving out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL.
REQ-027 Reset SHALL take priority over flush, accept and pop; words held or presented during reset SHALL be lost.
REQ-028 The first accept SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-029 Reset, then in_data=0x11 valid 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x11; following cycle out_valid=0, occupancy=0.
REQ-030 out_ready=0, push 0xA1, 0xA2 -> occupancy=2, in_ready=0, out_data=0xA1; a third word 0xA3 is not accepted; then out_ready=1 -> out sequence 0xA1, 0xA2 in consecutive cycles.
REQ-031 in_valid=1, out_ready=1 for 8 cycles with data 0..7 -> outputs 0..7 in order one per cycle, occupancy constant 1 after the first cycle.
REQ-032 FULL with 0xB1/0xB2, assert flush together with in_valid=1 (0xB3) and out_ready=1 -> next cycle out_valid=0, occupancy=0, and 0xB3 never appears at the output.
REQ-033 FULL, assert clkrst_core_rst for one cycle -> out_valid=0, in_ready=1, out_data=RESET_VAL; push 0xC1 in the next cycle -> 0xC1 output one cycle later.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register (main + skid). Handshake outputs come
// straight from flops, so neither in_ready nor out_valid depends combinationally on the inputs.
module pipe_skid_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clkrst_core_clk,
    input  logic             clkrst_core_rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             accept_s;
    logic             pop_s;
    logic             load_main_s;
    logic             load_skid_s;
    logic             main_from_skid_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic [1:0]       occupancy_s;

    assign out_data = main_r;

    // Next-state and data-load decode; flush overrides every transition and load.
    always_comb begin
        accept_s         = in_valid && in_ready;
        pop_s            = out_valid && out_ready;
        next_s           = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    next_s      = ST_BUSY;
                    load_main_s = 1'b1;
                end else begin
                    next_s = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (accept_s && !pop_s) begin
                    next_s      = ST_FULL;
                    load_skid_s = 1'b1;
                end else if (pop_s && !accept_s) begin
                    next_s = ST_EMPTY;
                end else if (accept_s && pop_s) begin
                    next_s      = ST_BUSY;
                    load_main_s = 1'b1;
                end else begin
                    next_s = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    next_s           = ST_BUSY;
                    main_from_skid_s = 1'b1;
                end else begin
                    next_s = ST_FULL;
                end
            end
            default: begin
                next_s = ST_EMPTY;
            end
        endcase
        if (flush) begin
            next_s           = ST_EMPTY;
            load_main_s      = 1'b0;
            load_skid_s      = 1'b0;
            main_from_skid_s = 1'b0;
        end else begin
            next_s = next_s;
        end
    end

    // Handshake/occupancy values for the upcoming state, registered below.
    always_comb begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        occupancy_s = 2'd0;
        case (next_s)
            ST_EMPTY: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                occupancy_s = 2'd0;
            end
            ST_BUSY: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b1;
                occupancy_s = 2'd1;
            end
            ST_FULL: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
                occupancy_s = 2'd2;
            end
            default: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                occupancy_s = 2'd0;
            end
        endcase
    end

    // State, registered outputs and data registers.
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state_r   <= ST_EMPTY;
            main_r    <= RESET_VAL;
            skid_r    <= RESET_VAL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state_r   <= next_s;
            in_ready  <= in_ready_s;
            out_valid <= out_valid_s;
            occupancy <= occupancy_s;
            if (load_main_s) begin
                main_r <= in_data;
            end else if (main_from_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic, all checked
// against a queue-based model of a 2-deep in-order buffer.
module tb_pipe_skid_reg;

    localparam int         WIDTH = 8;
    localparam logic [7:0] RVAL  = 8'h5A;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [1:0]       occupancy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] shown;
    bit         known = 1'b0;

    pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RVAL)) dut (
        .clkrst_core_clk(clk),
        .clkrst_core_rst(rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .flush          (flush),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to model, advance model.
    task automatic cyc(input logic v, input logic [7:0] d, input logic ordy,
                       input logic fl, input logic rs);
        bit acc;
        bit pop;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        if (known) begin
            check_eq("in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
            check_eq("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
            check_eq("occupancy", {30'd0, occupancy}, mq.size());
            check_eq("out_data",  {24'd0, out_data},  {24'd0, shown});
        end
        if (rs) begin
            mq.delete();
            shown = RVAL;
            known = 1'b1;
        end else if (fl) begin
            mq.delete();
        end else begin
            acc = v && (mq.size() < 2);
            pop = ordy && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            if (mq.size() > 0) shown = mq[0];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
        @(negedge clk);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        #1;
        check_eq("reset_out_data", {24'd0, out_data}, {24'd0, RVAL});
        check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Single word, one-cycle latency
        cyc(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        #1;
        check_eq("lat_valid", {31'd0, out_valid}, 32'd1);
        check_eq("lat_data",  {24'd0, out_data},  32'h11);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fill, stall, then drain
        cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("full_occ",   {30'd0, occupancy}, 32'd2);
        check_eq("full_ready", {31'd0, in_ready},  32'd0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        check_eq("drain_second", {24'd0, out_data}, 32'hA2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Streaming 0..7
        for (int i = 0; i < 8; i++) cyc(1'b1, i[7:0], 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush from FULL discards the word offered alongside it
        cyc(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hB3, 1'b1, 1'b1, 1'b0);
        #1;
        check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_hold",  {24'd0, out_data},  32'hB1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset from FULL, then immediate accept
        cyc(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hD3, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("post_rst_data", {24'd0, out_data}, 32'hC1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                ($urandom % 40) == 0, ($urandom % 97) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
